// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: buffers commands in a small FIFO, drives them one at a
// time onto the ALU inputs, and returns each registered 16-bit result over valid/ready.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    output logic [7:0]       alu_in0,
    output logic [7:0]       alu_in1,
    output logic [2:0]       alu_sel,
    output logic             alu_en,
    input  logic [15:0]      alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic [2:0]       res_op,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESULT
    } state_e;

    state_e           state_q;
    logic [18:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ready_q;
    logic [7:0]       in0_q;
    logic [7:0]       in1_q;
    logic [2:0]       sel_q;
    logic             en_q;
    logic             res_valid_q;
    logic [15:0]      res_data_q;
    logic [2:0]       res_op_q;
    logic             push;
    logic             pop;
    logic [18:0]      head;

    // A pop happens only when the FSM is free to start a new command.
    assign push = cmd_valid && ready_q;
    assign pop  = (count_q != '0) &&
                  ((state_q == IDLE) || ((state_q == RESULT) && res_ready));
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            in0_q       <= '0;
            in1_q       <= '0;
            sel_q       <= '0;
            en_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d < DEPTH_C);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case (state_q)
                IDLE: begin
                    en_q <= 1'b0;
                    if (pop) begin
                        {sel_q, in0_q, in1_q} <= head;
                        en_q                  <= 1'b1;
                        state_q               <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_data_q  <= alu_out;
                    res_op_q    <= sel_q;
                    res_valid_q <= 1'b1;
                    en_q        <= 1'b0;
                    state_q     <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (pop) begin
                            {sel_q, in0_q, in1_q} <= head;
                            en_q                  <= 1'b1;
                            state_q               <= ISSUE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign alu_in0   = in0_q;
    assign alu_in1   = in1_q;
    assign alu_sel   = sel_q;
    assign alu_en    = en_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign busy      = (state_q != IDLE) || (count_q != '0);
    assign count     = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU on the tri-state bus, a command-order
// scoreboard checked at every issue/retire, and directed timing/reset/full-FIFO steps.
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [7:0]  alu_in0;
    logic [7:0]  alu_in1;
    logic [2:0]  alu_sel;
    logic        alu_en;
    logic [15:0] alu_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_op;
    logic        busy;
    logic [2:0]  count;

    int          checkCount = 0;
    int          passCount  = 0;
    int          cycle      = 0;
    logic        prevEn     = 1'b0;
    logic [18:0] expQ[$];
    int          retireCyc[$];
    logic [15:0] retireDat[$];

    alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_sel(alu_sel), .alu_en(alu_en),
        .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op),
        .busy(busy), .count(count)
    );

    // What the 8-bit ALU computes; shifts move operand A by one place.
    function automatic logic [15:0] aluFn(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            3'd0:    return {8'h00, a} + {8'h00, b};
            3'd1:    return {8'h00, a} - {8'h00, b};
            3'd2:    return {9'h000, a[7:1]};
            3'd3:    return {7'h00, a, 1'b0};
            3'd4:    return {8'h00, a & b};
            3'd5:    return {8'h00, a | b};
            3'd6:    return {8'h00, a ^ b};
            default: return {8'h00, ~a};
        endcase
    endfunction

    // Undriven bus reads as unknown so a capture outside ISSUE cannot match.
    assign alu_out = alu_en ? aluFn(alu_sel, alu_in0, alu_in1) : 16'hxxxx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [7:0] a,
                                 input logic [7:0] b);
        cmd_valid = v;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitResult(input int maxCycles, input string tag);
        int n = 0;
        while (!res_valid && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput(tag, res_valid, 1);
    endtask

    task automatic waitIdle(input int maxCycles, input string tag);
        int n = 0;
        while ((busy || res_valid) && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput(tag, busy || res_valid, 0);
    endtask

    // Scoreboard monitor sampled mid-cycle: retire, then issue, then accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevEn = 1'b0;
        end else begin
            cycle++;
            if (res_valid && res_ready) begin
                checkOutput("retire_expected", expQ.size() != 0, 1);
                if (expQ.size() != 0) begin
                    checkOutput("retire_result", {13'h0, res_op, res_data},
                                {13'h0, expQ[0][18:16], aluFn(expQ[0][18:16], expQ[0][15:8], expQ[0][7:0])});
                    void'(expQ.pop_front());
                    retireCyc.push_back(cycle);
                    retireDat.push_back(res_data);
                end
            end
            if (alu_en) begin
                checkOutput("en_not_back_to_back", prevEn, 0);
                checkOutput("issue_expected", expQ.size() != 0, 1);
                if (expQ.size() != 0) begin
                    checkOutput("issue_operands", {alu_sel, alu_in0, alu_in1}, expQ[0]);
                end
            end
            prevEn = alu_en;
            if (cmd_valid && cmd_ready) begin
                expQ.push_back({cmd_op, cmd_a, cmd_b});
            end
        end
    end

    initial begin
        logic [7:0]  a0;
        logic [7:0]  b0;
        logic [15:0] firstRes;
        int          nBefore;
        int          n;

        $display("[TB] start");
        rst_n     = 1'b0;
        res_ready = 1'b0;
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (2) tick();

        // Everything is zero while held in reset.
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_alu_en", alu_en, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_alu_bus", {alu_sel, alu_in0, alu_in1}, 0);
        checkOutput("rst_res", {res_op, res_data}, 0);

        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_cmd_ready", cmd_ready, 1);

        // Single ADD: issue one edge after the push, result one edge later.
        res_ready = 1'b1;
        applyStimulus(1'b1, 3'd0, 8'hFF, 8'h01);
        tick();
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
        checkOutput("add_count_after_push", count, 1);
        checkOutput("add_en_before_issue", alu_en, 0);
        tick();
        checkOutput("add_en_issue", alu_en, 1);
        tick();
        checkOutput("add_en_dropped", alu_en, 0);
        checkOutput("add_res_valid", res_valid, 1);
        checkOutput("add_res_data", res_data, 16'h0100);
        checkOutput("add_res_op", res_op, 3'd0);
        tick();
        checkOutput("add_res_valid_cleared", res_valid, 0);
        checkOutput("add_busy_cleared", busy, 0);

        // Back-to-back SUB, SHL, SHR: one result every two cycles, in order.
        nBefore = retireCyc.size();
        applyStimulus(1'b1, 3'd1, 8'h03, 8'h05);
        tick();
        applyStimulus(1'b1, 3'd3, 8'h80, 8'h01);
        tick();
        applyStimulus(1'b1, 3'd2, 8'h81, 8'h01);
        tick();
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
        waitIdle(20, "b2b_drain_timeout");
        n = retireCyc.size();
        checkOutput("b2b_result_count", n - nBefore, 3);
        if (n - nBefore == 3) begin
            checkOutput("b2b_sub", retireDat[n-3], 16'hFFFE);
            checkOutput("b2b_shl", retireDat[n-2], 16'h0100);
            checkOutput("b2b_shr", retireDat[n-1], 16'h0040);
            checkOutput("b2b_gap1", retireCyc[n-2] - retireCyc[n-3], 2);
            checkOutput("b2b_gap2", retireCyc[n-1] - retireCyc[n-2], 2);
        end

        // Stall the result and overfill the FIFO with ADDs.
        res_ready = 1'b0;
        nBefore   = retireCyc.size();
        a0        = 8'($urandom);
        b0        = 8'($urandom);
        firstRes  = {8'h00, a0} + {8'h00, b0};
        applyStimulus(1'b1, 3'd0, a0, b0);
        tick();
        for (int i = 1; i < 6; i++) begin
            applyStimulus(1'b1, 3'd0, 8'($urandom), 8'($urandom));
            tick();
        end
        checkOutput("full_count", count, 4);
        checkOutput("full_cmd_ready", cmd_ready, 0);
        checkOutput("stall_res_valid", res_valid, 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_res_data", res_data, firstRes);
            checkOutput("stall_count", count, 4);
            tick();
        end
        // Pop while full with cmd_valid still high: no push-through.
        res_ready = 1'b1;
        tick();
        checkOutput("full_pop_count", count, 3);
        checkOutput("full_pop_ready", cmd_ready, 1);
        tick();
        checkOutput("full_refill_count", count, 4);
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
        waitIdle(40, "full_drain_timeout");
        checkOutput("full_results", retireCyc.size() - nBefore, 6);
        checkOutput("full_queue_empty", expQ.size(), 0);

        // Reset during ISSUE with two entries still queued.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
        res_ready = 1'b1;
        tick();
        checkOutput("pre_rst_issue", alu_en, 1);
        checkOutput("pre_rst_count", count, 2);
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("async_rst_en", alu_en, 0);
        checkOutput("async_rst_res_valid", res_valid, 0);
        checkOutput("async_rst_count", count, 0);
        checkOutput("async_rst_cmd_ready", cmd_ready, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_rst_no_result", res_valid, 0);
            checkOutput("post_rst_count", count, 0);
        end
        applyStimulus(1'b1, 3'd6, 8'hF0, 8'h3C);
        tick();
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
        waitResult(10, "xor_timeout");
        checkOutput("xor_res_data", res_data, 16'h00CC);
        checkOutput("xor_res_op", res_op, 3'd6);
        waitIdle(10, "xor_drain_timeout");

        // Quiet bus while idle.
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("idle_en", alu_en, 0);
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_res_valid", res_valid, 0);
        end

        // Random traffic with random backpressure, judged by the scoreboard.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 8'($urandom));
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
        res_ready = 1'b1;
        waitIdle(60, "rand_drain_timeout");
        checkOutput("rand_queue_empty", expQ.size(), 0);
        checkOutput("rand_count_zero", count, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream issue stage for the 8-bit ALU. It accepts operation commands (opcode plus two operands) on a valid/ready interface and buffers them in a small FIFO. It drives them one at a time onto the ALU's in0/in1/sel/en inputs, then registers the ALU's 16-bit result and presents it downstream on a valid/ready interface. It is the only block that asserts the ALU enable, so the ALU output bus stays high-Z whenever no operation is in flight.

Parameters:
FIFO_DEPTH, 4, number of command entries; power of two, minimum 2.
CNT_W, $clog2(FIFO_DEPTH+1), width of the occupancy count.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 SHR, 011 SHL, 100 AND, 101 OR, 110 XOR, 111 NOT
cmd_a  in  8  operand A, drives ALU in0
cmd_b  in  8  operand B, drives ALU in1
alu_in0  out  8  to ALU in0
alu_in1  out  8  to ALU in1
alu_sel  out  3  to ALU sel
alu_en  out  1  to ALU en
alu_out  in  16  from ALU out, combinational
res_valid  out  1  result available
res_ready  in  1  downstream accepts the result
res_data  out  16  captured ALU result
res_op  out  3  opcode that produced res_data
busy  out  1  high when state is not IDLE or the FIFO is non-empty
count  out  CNT_W  FIFO occupancy

Behaviour:
- Reset: one clock domain, clk. rst_n is asynchronous and active-low; it asserts immediately and releases synchronously to clk.
  - All outputs go to 0: cmd_ready=0 while in reset, then 1 after release.
  - FIFO pointers and count are cleared; state goes to IDLE.
  - Asserting reset mid-operation drops alu_en immediately and discards any in-flight or unconsumed result.
- FIFO:
  - Push occurs on a clk edge when cmd_valid && cmd_ready.
  - cmd_ready = (count < FIFO_DEPTH). When full it stays 0 even if a pop happens in the same cycle; no push-through when full.
  - Simultaneous push and pop with count < FIFO_DEPTH leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - cmd_* inputs are ignored while cmd_valid=0.
- State IDLE:
  - alu_en=0; alu_in0, alu_in1 and alu_sel hold their last values.
  - If count>0: pop the head entry, register it onto alu_in0/alu_in1/alu_sel, set alu_en=1, and go to ISSUE.
- State ISSUE (exactly 1 cycle):
  - alu_en=1 and operands are stable for the whole cycle.
  - At the closing edge: res_data<=alu_out, res_op<=alu_sel, res_valid<=1, alu_en<=0, go to RESULT.
- State RESULT:
  - res_valid=1; res_data and res_op are held stable until res_ready=1.
  - On the res_valid && res_ready edge: if count>0, pop the next entry and go to ISSUE (res_valid<=0, alu_en<=1). Otherwise go to IDLE with res_valid<=0.
- Timing:
  - Latency: a command pushed at edge N into an empty FIFO while in IDLE is issued at edge N+1; res_valid rises at edge N+2.
  - Throughput: one result every 2 cycles with res_ready held high.
- alu_en is high only in ISSUE, never in IDLE or RESULT. This is required because the ALU output is a shared tri-state bus.
- Result width: res_data is the full 16-bit ALU output, passed through unmodified. No sign or width processing happens in this block.
- Ordering: results leave in strict command order. No command is dropped or duplicated.

Test Plan:
- Reset, then push ADD a=0xFF b=0x01 with res_ready=1 -> cmd_ready=1 after reset; alu_en high for exactly 1 cycle; res_valid 2 edges after push; res_data=0x0100, res_op=000; busy returns to 0.
- Push SUB a=0x03 b=0x05, SHL a=0x80, SHR a=0x81 back-to-back with res_ready=1 -> results 0xFFFE, 0x0100, 0x0040 in that order, one every 2 cycles; alu_en never high in two consecutive cycles.
- res_ready=0, push 6 ADD commands on consecutive cycles -> first result issued and held; FIFO fills to 4; cmd_ready drops to 0 with count=4; res_data stays stable while stalled. Release res_ready -> all 5 accepted commands complete in order.
- Full FIFO with cmd_valid=1 while a pop occurs in the same cycle -> no push that cycle; count goes from 4 to 3; push succeeds the following cycle.
- Assert rst_n low during ISSUE with 2 entries queued -> alu_en, res_valid and count go to 0 without waiting for a clock edge; after release there is no spurious result, and the next pushed command (XOR 0xF0,0x3C) yields 0x00CC.
- Idle for 10 cycles after the queue drains -> alu_en=0 throughout (ALU output high-Z); busy=0; res_valid=0.
